// File: rtl/pc_gen_pkg.sv
// Shared types and helpers for the multi-hart fetch PC generator.
// Field widths are fixed maxima so the same types serve every build of the block.
package pc_gen_pkg;

    localparam int ILEN_COMPRESSED = 2;
    localparam int ILEN_WORD       = 4;

    localparam int HART_ID_MAX_W = 8;
    localparam int PC_MAX_W      = 64;

    typedef logic [HART_ID_MAX_W-1:0] hart_id_t;

    typedef struct packed {
        logic                valid;
        hart_id_t            hart;
        logic [PC_MAX_W-1:0] pc;
    } redirect_t;

    // Only the two lowest PC bits are ever cleared by alignment, so callers
    // pass those bits in and splice the result back under the upper PC bits.
    function automatic logic [1:0] align_pc(input logic [1:0] pc_low, input int ilen_bytes);
        if (ilen_bytes == ILEN_COMPRESSED) begin
            return {pc_low[1], 1'b0};
        end
        return 2'b00;
    endfunction

endpackage

// File: rtl/pc_gen_mt_hart_rr_select.sv
// Rotating-priority picker: returns the first set mask bit at or after ptr,
// wrapping around. Also used by the issue stage.
module hart_rr_select #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] mask,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] sel,
    output logic         any
);

    int         idx_int;
    logic [W-1:0] idx;
    logic       found;

    always_comb begin
        sel     = '0;
        found   = 1'b0;
        idx_int = 0;
        idx     = '0;
        for (int i = 0; i < N; i++) begin
            idx_int = int'(ptr) + i;
            if (idx_int >= N) begin
                idx_int = idx_int - N;
            end
            idx = W'(idx_int);
            if (!found && mask[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    assign any = |mask;

endmodule

// File: rtl/pc_gen_mt.sv
// Multi-hart fetch PC generator: one PC per hart, round-robin hart selection,
// valid/ready fetch handshake with request locking, and per-hart redirects.
module pc_gen_mt
    import pc_gen_pkg::*;
#(
    parameter int               XLEN         = 32,
    parameter int               NUM_HARTS    = 4,
    parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
    parameter int               ILEN_BYTES   = 4,
    localparam int              HART_W       = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_HARTS-1:0] hart_enable,
    output logic                 fetch_valid,
    input  logic                 fetch_ready,
    output logic [XLEN-1:0]      fetch_pc,
    output logic [HART_W-1:0]    fetch_hart,
    input  logic                 redirect_valid,
    input  logic [HART_W-1:0]    redirect_hart,
    input  logic [XLEN-1:0]      redirect_pc
);

    logic [XLEN-1:0]   pc_q [NUM_HARTS];
    logic [XLEN-1:0]   pc_d [NUM_HARTS];
    logic [HART_W-1:0] rr_ptr_q, rr_ptr_d;
    logic              locked_q, locked_d;
    logic [HART_W-1:0] locked_hart_q, locked_hart_d;

    logic [HART_W-1:0] rr_sel;
    logic [HART_W-1:0] sel;
    logic              any_enabled;
    logic              fire;

    redirect_t         redir;
    logic              redir_hit;
    logic [HART_W-1:0] redir_idx;
    logic [XLEN-1:0]   redir_pc_aligned;

    hart_rr_select #(
        .N (NUM_HARTS),
        .W (HART_W)
    ) u_rr_select (
        .mask (hart_enable),
        .ptr  (rr_ptr_q),
        .sel  (rr_sel),
        .any  (any_enabled)
    );

    // A backpressured request stays pinned to its hart until it is accepted.
    assign sel = locked_q ? locked_hart_q : rr_sel;

    // Outputs are forced idle combinationally so they drop the instant reset asserts.
    assign fetch_valid = reset_n & (locked_q | any_enabled);
    assign fetch_hart  = reset_n ? sel : '0;
    assign fetch_pc    = reset_n ? pc_q[sel] : RESET_VECTOR;
    assign fire        = fetch_valid & fetch_ready;

    always_comb begin
        redir.valid = redirect_valid;
        redir.hart  = hart_id_t'(redirect_hart);
        redir.pc    = PC_MAX_W'(redirect_pc);
    end

    assign redir_hit        = redir.valid && (int'(redir.hart) < NUM_HARTS);
    assign redir_idx        = redir.hart[HART_W-1:0];
    assign redir_pc_aligned = {redir.pc[XLEN-1:2], align_pc(redir.pc[1:0], ILEN_BYTES)};

    if (XLEN < PC_MAX_W) begin : g_pc_hi
        logic unused_pc_hi;
        assign unused_pc_hi = |redir.pc[PC_MAX_W-1:XLEN];
    end

    // The redirect is applied last so it overrides a same-hart increment.
    always_comb begin
        pc_d = pc_q;
        if (fire) begin
            pc_d[sel] = pc_q[sel] + XLEN'(ILEN_BYTES);
        end
        if (redir_hit) begin
            pc_d[redir_idx] = redir_pc_aligned;
        end
    end

    always_comb begin
        rr_ptr_d      = rr_ptr_q;
        locked_d      = locked_q;
        locked_hart_d = locked_hart_q;
        if (fire) begin
            rr_ptr_d = (sel == HART_W'(NUM_HARTS - 1)) ? '0 : sel + HART_W'(1);
            locked_d = 1'b0;
        end else if (fetch_valid) begin
            locked_d      = 1'b1;
            locked_hart_d = sel;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int h = 0; h < NUM_HARTS; h++) begin
                pc_q[h] <= RESET_VECTOR;
            end
            rr_ptr_q      <= '0;
            locked_q      <= 1'b0;
            locked_hart_q <= '0;
        end else begin
            pc_q          <= pc_d;
            rr_ptr_q      <= rr_ptr_d;
            locked_q      <= locked_d;
            locked_hart_q <= locked_hart_d;
        end
    end

endmodule

// File: tb/tb_pc_gen_mt.sv
// Self-checking bench for pc_gen_mt: directed vector table, hand-written
// corner sequences, and randomized traffic against a behavioural model.
module tb_pc_gen_mt;

    localparam logic [31:0] RV = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  hart_enable;
    logic        fetch_ready;
    logic        redirect_valid;
    logic [1:0]  redirect_hart;
    logic [31:0] redirect_pc;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [1:0]  fetch_hart;

    logic [4:0]  hart_enable5;
    logic        fetch_ready5;
    logic        redirect_valid5;
    logic [2:0]  redirect_hart5;
    logic [31:0] redirect_pc5;
    logic        fetch_valid5;
    logic [31:0] fetch_pc5;
    logic [2:0]  fetch_hart5;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_pc [4];
    int          m_rr;
    bit          m_locked;
    int          m_lh;

    typedef struct {
        logic [3:0]  en;
        logic        rdy;
        logic        ev;
        logic        chk;
        logic [1:0]  eh;
        logic [31:0] epc;
    } vec_t;

    vec_t tbl [18];

    always #5 clk = ~clk;

    pc_gen_mt #(.XLEN(32), .NUM_HARTS(4), .RESET_VECTOR(RV), .ILEN_BYTES(4)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .hart_enable    (hart_enable),
        .fetch_valid    (fetch_valid),
        .fetch_ready    (fetch_ready),
        .fetch_pc       (fetch_pc),
        .fetch_hart     (fetch_hart),
        .redirect_valid (redirect_valid),
        .redirect_hart  (redirect_hart),
        .redirect_pc    (redirect_pc)
    );

    pc_gen_mt #(.XLEN(32), .NUM_HARTS(5), .RESET_VECTOR(32'h0), .ILEN_BYTES(2)) dut5 (
        .clk            (clk),
        .reset_n        (reset_n),
        .hart_enable    (hart_enable5),
        .fetch_valid    (fetch_valid5),
        .fetch_ready    (fetch_ready5),
        .fetch_pc       (fetch_pc5),
        .fetch_hart     (fetch_hart5),
        .redirect_valid (redirect_valid5),
        .redirect_hart  (redirect_hart5),
        .redirect_pc    (redirect_pc5)
    );

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int h = 0; h < 4; h++) m_pc[h] = RV;
        m_rr     = 0;
        m_locked = 1'b0;
        m_lh     = 0;
    endfunction

    // The chosen hart is the enabled one at the smallest forward distance from m_rr.
    function automatic void model_outs(input logic [3:0] en, output bit v, output int h);
        v = m_locked || (en != 4'b0);
        h = 0;
        if (m_locked) begin
            h = m_lh;
        end else begin
            for (int k = 3; k >= 0; k--) begin
                if (en[2'((m_rr + k) % 4)]) h = (m_rr + k) % 4;
            end
        end
    endfunction

    function automatic void model_tick();
        bit v;
        int h;
        model_outs(hart_enable, v, h);
        if (v && fetch_ready) begin
            m_pc[2'(h)] = m_pc[2'(h)] + 32'd4;
            m_rr        = (h + 1) % 4;
            m_locked    = 1'b0;
        end else if (v) begin
            m_locked = 1'b1;
            m_lh     = h;
        end
        if (redirect_valid) m_pc[redirect_hart] = redirect_pc & ~32'h3;
    endfunction

    task automatic apply_stimulus(input logic [3:0] en, input logic rdy, input logic rv,
                                  input logic [1:0] rh, input logic [31:0] rpc);
        hart_enable    = en;
        fetch_ready    = rdy;
        redirect_valid = rv;
        redirect_hart  = rh;
        redirect_pc    = rpc;
    endtask

    task automatic step_check(input string name, input bit ev, input bit chk,
                              input logic [1:0] eh, input logic [31:0] epc);
        @(negedge clk);
        check_output({name, ".valid"}, 32'(fetch_valid), 32'(ev));
        if (chk) begin
            check_output({name, ".hart"}, 32'(fetch_hart), 32'(eh));
            check_output({name, ".pc"}, fetch_pc, epc);
        end
        @(posedge clk);
        model_tick();
        #1;
    endtask

    task automatic step_check5(input string name, input bit ev, input bit chk,
                               input logic [2:0] eh, input logic [31:0] epc);
        @(negedge clk);
        check_output({name, ".valid"}, 32'(fetch_valid5), 32'(ev));
        if (chk) begin
            check_output({name, ".hart"}, 32'(fetch_hart5), 32'(eh));
            check_output({name, ".pc"}, fetch_pc5, epc);
        end
        @(posedge clk);
        model_tick();
        #1;
    endtask

    initial begin
        bit          v;
        int          h;
        logic [3:0]  en;
        logic [31:0] rpc;

        tbl[0]  = '{4'hF, 1'b1, 1'b1, 1'b1, 2'd0, 32'h8000_0000};
        tbl[1]  = '{4'hF, 1'b1, 1'b1, 1'b1, 2'd1, 32'h8000_0000};
        tbl[2]  = '{4'hF, 1'b1, 1'b1, 1'b1, 2'd2, 32'h8000_0000};
        tbl[3]  = '{4'hF, 1'b1, 1'b1, 1'b1, 2'd3, 32'h8000_0000};
        tbl[4]  = '{4'hF, 1'b1, 1'b1, 1'b1, 2'd0, 32'h8000_0004};
        tbl[5]  = '{4'hF, 1'b1, 1'b1, 1'b1, 2'd1, 32'h8000_0004};
        tbl[6]  = '{4'hF, 1'b0, 1'b1, 1'b1, 2'd2, 32'h8000_0004};
        tbl[7]  = '{4'hB, 1'b0, 1'b1, 1'b1, 2'd2, 32'h8000_0004};
        tbl[8]  = '{4'hB, 1'b0, 1'b1, 1'b1, 2'd2, 32'h8000_0004};
        tbl[9]  = '{4'hB, 1'b1, 1'b1, 1'b1, 2'd2, 32'h8000_0004};
        tbl[10] = '{4'hB, 1'b1, 1'b1, 1'b1, 2'd3, 32'h8000_0004};
        tbl[11] = '{4'hA, 1'b1, 1'b1, 1'b1, 2'd1, 32'h8000_0008};
        tbl[12] = '{4'hA, 1'b1, 1'b1, 1'b1, 2'd3, 32'h8000_0008};
        tbl[13] = '{4'hA, 1'b1, 1'b1, 1'b1, 2'd1, 32'h8000_000C};
        tbl[14] = '{4'hA, 1'b1, 1'b1, 1'b1, 2'd3, 32'h8000_000C};
        tbl[15] = '{4'h0, 1'b1, 1'b0, 1'b0, 2'd0, 32'h0};
        tbl[16] = '{4'h0, 1'b1, 1'b0, 1'b0, 2'd0, 32'h0};
        tbl[17] = '{4'hF, 1'b1, 1'b1, 1'b1, 2'd0, 32'h8000_0008};

        reset_n         = 1'b0;
        apply_stimulus(4'hF, 1'b1, 1'b0, 2'd0, 32'h0);
        hart_enable5    = '0;
        fetch_ready5    = 1'b1;
        redirect_valid5 = 1'b0;
        redirect_hart5  = '0;
        redirect_pc5    = '0;
        model_reset();

        @(negedge clk);
        check_output("reset.valid", 32'(fetch_valid), 32'd0);
        check_output("reset.hart", 32'(fetch_hart), 32'd0);
        check_output("reset.pc", fetch_pc, RV);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            apply_stimulus(tbl[i].en, tbl[i].rdy, 1'b0, 2'd0, 32'h0);
            step_check($sformatf("vec%0d", i), tbl[i].ev, tbl[i].chk, tbl[i].eh, tbl[i].epc);
        end

        // Fire and redirect on the same hart in the same cycle
        apply_stimulus(4'h0, 1'b1, 1'b1, 2'd1, 32'h0000_0100);
        step_check("coll_setup", 1'b0, 1'b0, 2'd0, 32'h0);
        apply_stimulus(4'h2, 1'b1, 1'b1, 2'd1, 32'h0000_2003);
        step_check("coll_fire", 1'b1, 1'b1, 2'd1, 32'h0000_0100);
        apply_stimulus(4'h2, 1'b1, 1'b0, 2'd0, 32'h0);
        step_check("coll_after", 1'b1, 1'b1, 2'd1, 32'h0000_2000);

        // PC wrap at the top of the address space
        apply_stimulus(4'h0, 1'b1, 1'b1, 2'd0, 32'hFFFF_FFFC);
        step_check("wrap_setup", 1'b0, 1'b0, 2'd0, 32'h0);
        apply_stimulus(4'h1, 1'b1, 1'b0, 2'd0, 32'h0);
        step_check("wrap_top", 1'b1, 1'b1, 2'd0, 32'hFFFF_FFFC);
        step_check("wrap_zero", 1'b1, 1'b1, 2'd0, 32'h0000_0000);

        // Redirect on a locked hart whose enable has dropped
        apply_stimulus(4'h4, 1'b0, 1'b0, 2'd0, 32'h0);
        step_check("lockred_lock", 1'b1, 1'b1, 2'd2, 32'h8000_0008);
        apply_stimulus(4'h0, 1'b0, 1'b1, 2'd2, 32'h0000_3000);
        step_check("lockred_hold", 1'b1, 1'b1, 2'd2, 32'h8000_0008);
        apply_stimulus(4'h0, 1'b1, 1'b0, 2'd0, 32'h0);
        step_check("lockred_new", 1'b1, 1'b1, 2'd2, 32'h0000_3000);
        step_check("lockred_idle", 1'b0, 1'b0, 2'd0, 32'h0);

        // Five-hart build: out-of-range redirect ids and 2-byte alignment
        redirect_valid5 = 1'b1;
        redirect_hart5  = 3'd5;
        redirect_pc5    = 32'h0000_1234;
        step_check5("oor5", 1'b0, 1'b0, 3'd0, 32'h0);
        redirect_hart5  = 3'd7;
        redirect_pc5    = 32'h0000_5678;
        step_check5("oor7", 1'b0, 1'b0, 3'd0, 32'h0);
        redirect_hart5  = 3'd4;
        redirect_pc5    = 32'h0000_4447;
        step_check5("red4", 1'b0, 1'b0, 3'd0, 32'h0);
        redirect_valid5 = 1'b0;
        hart_enable5    = 5'h1F;
        for (int i = 0; i < 4; i++) begin
            step_check5($sformatf("h5_%0d", i), 1'b1, 1'b1, 3'(i), 32'h0);
        end
        step_check5("h5_4", 1'b1, 1'b1, 3'd4, 32'h0000_4446);
        step_check5("h5_inc", 1'b1, 1'b1, 3'd0, 32'h0000_0002);
        hart_enable5 = '0;

        // Asynchronous reset between clock edges while a request is locked
        apply_stimulus(4'hF, 1'b0, 1'b0, 2'd0, 32'h0);
        step_check("arst_lock", 1'b1, 1'b1, 2'd3, 32'h8000_0010);
        #2;
        reset_n = 1'b0;
        #1;
        check_output("arst.valid", 32'(fetch_valid), 32'd0);
        check_output("arst.hart", 32'(fetch_hart), 32'd0);
        check_output("arst.pc", fetch_pc, RV);
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        apply_stimulus(4'hF, 1'b1, 1'b0, 2'd0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            step_check($sformatf("arst_rr%0d", i), 1'b1, 1'b1, 2'(i), RV);
        end
        step_check("arst_rr4", 1'b1, 1'b1, 2'd0, RV + 32'd4);

        for (int i = 0; i < 400; i++) begin
            en = 4'($urandom);
            if ($urandom_range(0, 7) == 0) en = 4'h0;
            rpc = $urandom;
            if ($urandom_range(0, 7) == 0) rpc = {30'h3FFF_FFFF, 2'($urandom)};
            apply_stimulus(en, ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0),
                           2'($urandom), rpc);
            model_outs(hart_enable, v, h);
            step_check($sformatf("rnd%0d", i), v, v, 2'(h), m_pc[2'(h)]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
